// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the ALU round-robin arbiter: FSM state encoding and
// the watchdog counter width.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    WAIT  = 2'b10
  } arb_state_e;

  localparam int unsigned WD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit of req searching
// ptr, ptr+1, ... wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned SW = $clog2(N);

  logic [SW-1:0] pos;

  // Scan from the lowest priority upward so the highest-priority hit wins last.
  always_comb begin
    pick = '0;
    idx  = '0;
    pos  = '0;
    any  = |req;
    for (int k = N - 1; k >= 0; k--) begin
      pos = SW'((int'(ptr) + k) % N);
      if (req[pos]) begin
        pick      = '0;
        pick[pos] = 1'b1;
        idx       = pos;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU slice among N requesters.
// Optional watchdog that revokes stuck grants is enabled by ARB_TIMEOUT_EN.
module alu_rr_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 start,
  input  logic                 done,
  output logic                 busy,
  output logic                 timeout
);

  localparam int unsigned SW = $clog2(N);

  arb_state_e    state, state_next;
  logic [N-1:0]  gnt_next;
  logic [SW-1:0] sel_next;
  logic [SW-1:0] ptr, ptr_next;
  logic          start_next, busy_next, timeout_next;
  logic          complete;
  logic          wd_hit;

  logic [N-1:0]  pick;
  logic [SW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

`ifdef ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd, wd_next;

  // wd holds the number of WAIT cycles already completed; hit in the TIMEOUT-th one.
  assign wd_hit = (state == WAIT) && (wd == WD_W'(TIMEOUT - 1));
`else
  logic unused_cfg;

  assign wd_hit     = 1'b0;
  assign unused_cfg = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
      wd      <= '0;
`endif
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      sel     <= sel_next;
      start   <= start_next;
      busy    <= busy_next;
      timeout <= timeout_next;
      ptr     <= ptr_next;
`ifdef ARB_TIMEOUT_EN
      wd      <= wd_next;
`endif
    end
  end

  // The pick is registered first (IDLE with busy set); the following edge
  // launches start together with the move to GRANT, where done is first honoured.
  always_comb begin
    state_next   = state;
    gnt_next     = gnt;
    sel_next     = sel;
    busy_next    = busy;
    start_next   = 1'b0;
    timeout_next = 1'b0;
    ptr_next     = ptr;
    complete     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_next      = (state == WAIT) ? wd + 1'b1 : '0;
`endif

    case (state)
      IDLE: begin
        if (busy) begin
          state_next = GRANT;
          start_next = 1'b1;
        end else if (pick_any) begin
          gnt_next  = pick;
          sel_next  = pick_idx;
          busy_next = 1'b1;
        end
      end
      GRANT: begin
        if (done) complete = 1'b1;
        else      state_next = WAIT;
      end
      WAIT: begin
        if (done) begin
          complete = 1'b1;
        end else if (wd_hit) begin
          complete     = 1'b1;
          timeout_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (complete) begin
      state_next = IDLE;
      gnt_next   = '0;
      busy_next  = 1'b0;
      ptr_next   = (sel == SW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter that shares one multi-cycle execution resource (the shared ALU/CMOS datapath slice) among N requesters in the CPU. Requesters raise `req`; the arbiter grants one at a time, drives the datapath input-select and a start pulse, and holds the grant until the resource signals `done`. Rotating priority keeps any single requester from starving the others.

## Interface
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: watchdog limit in cycles, 1..255. Used only with `ARB_TIMEOUT_EN`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  request lines, level-sensitive, one bit per requester.
- `gnt`  out  N  one-hot grant; all zero when no grant is held.
- `sel`  out  clog2(N)  index of the granted requester, drives the datapath operand mux.
- `start`  out  1  one-cycle pulse to the shared resource.
- `done`  in  1  one-cycle completion pulse from the shared resource.
- `busy`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant; constant 0 without the macro.

## Operation
- States: IDLE, GRANT, WAIT.
- Priority pointer `ptr`, 0..N-1: highest-priority index. The search runs ptr, ptr+1, …, wrapping mod N.
- IDLE:
  - If `req` != 0, pick the first set bit in rotated order.
  - Register `gnt` (one-hot), `sel` and `busy`=1.
  - Go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: lasts exactly one cycle.
  - `start`=1.
  - If `done`=1 in this cycle, complete; otherwise go to WAIT.
- WAIT: hold `gnt`, `sel` and `busy`. Complete on `done`.
- Complete:
  - Clear `gnt` and `busy` at the next edge.
  - `ptr` <= (sel+1) mod N.
  - Go to IDLE.
- `sel` keeps its last value while in IDLE.
- Requester deasserting `req` while granted: ignored. The grant holds until complete.
- `done` in IDLE: ignored, no state change.
- New requests never preempt a held grant.
- Reset asserted at any time:
  - Immediately, asynchronously: state=IDLE, `gnt`=0, `sel`=0, `start`=0, `busy`=0, `timeout`=0, `ptr`=0, watchdog=0.
  - Any in-flight operation is abandoned.

## Timing
- `req` sampled at edge t:
  - `gnt`, `sel`, `busy` valid from t+1.
  - `start` high during t+2 (the GRANT cycle).
- `done` high in cycle k: `gnt`/`busy` low from k+1. IDLE occupies k+1.
- Earliest next grant at k+2.
- Minimum grant duration is 2 cycles (IDLE→GRANT→IDLE with `done` in the GRANT cycle).
- A single steady requester is granted every 3 cycles at best.
- All outputs are registered. There is no combinational path from `req` or `done` to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit watchdog counts cycles spent in WAIT and clears on entering GRANT.
  - If it reaches `TIMEOUT` with `done` still low, the grant is revoked as if completed.
  - `ptr` advances and `timeout` pulses high for the cycle in which `gnt` drops.
  - `done` and the limit arriving in the same cycle: treated as a normal completion, no `timeout`.
- `ARB_TIMEOUT_EN` undefined:
  - Counter and compare logic are absent; `timeout` is tied 0.
  - WAIT holds indefinitely until `done`.

## Structure
- Shared package `cpu_arb_pkg` holds:
  - state encoding: IDLE=2'b00, GRANT=2'b01, WAIT=2'b10;
  - the watchdog counter width (8).
- Sub-module `rr_pick`: combinational rotating priority encoder.
  - Inputs `req` and `ptr`; outputs a one-hot pick, its index, and `any`.
  - Instantiated once; it is independently testable.

## Test plan
- Single requester: N=4, reset, `req`=4'b0100 held, `done` 3 cycles after `start` → `gnt`=0100 and `sel`=2 one cycle after the edge; one `start` pulse; `gnt` drops the cycle after `done`; re-grant 2 cycles after `done`.
- Fairness: `req`=4'b1111 held, `done` in every GRANT cycle → grant order 0,1,2,3,0 with exactly one `start` per grant.
- Wrap-around: `ptr`=3 (after serving 2), `req`=4'b0101 → grants index 0, then 2.
- Stray `done` and dropped `req`:
  - `done` pulsed in IDLE → no output change;
  - `req` removed mid-WAIT → `gnt` held until `done`.
- Reset mid-operation: `rst_n` low during WAIT → `gnt`, `busy`, `start` go 0 without waiting for a clock edge; after release, `req`=0001 granted with `ptr`=0.
- Watchdog (`ARB_TIMEOUT_EN`, TIMEOUT=4): `done` never asserted → `gnt` drops and `timeout` pulses once after 4 WAIT cycles; the next requester is served. With `done` in the 4th WAIT cycle → no `timeout`.
